morse_encoder: RTL and testbench
================================

Name: morse_encoder

Overview:
- Transmit-side counterpart of the Morse `decoder`: accepts a 5-bit letter code (a=0 … z=25) over a valid/ready handshake.
- Serialises the letter as a 1-bit Morse time series with standard unit timing, on the same bit stream format that the `deserializer` front end consumes.
- Used as a stimulus source for the decoder and as the TX end of a loopback link.

Parameters:
- UNIT_CYCLES, 1, clock cycles per Morse time unit (≥1)
- CNT_W, $clog2(7*UNIT_CYCLES+1), width of the unit/cycle down-counter

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- letter  in  5  letter code, 0..25 valid
- in_valid  in  1  letter is presented
- in_ready  out  1  encoder can accept a letter this cycle
- out  out  1  Morse serial output, registered, 1 = key down
- busy  out  1  a letter (or gap) is being transmitted
- done  out  1  one-cycle pulse on the final cycle of a letter's inter-letter gap
- err  out  1  one-cycle pulse when an invalid code is accepted

Behaviour:
- Reset (async, rst_n=0): state=IDLE, out=0, in_ready=1, busy=0, done=0, err=0, counters cleared. Reset mid-letter aborts immediately; nothing resumes after release.
- Encoding: combinational table gives length (1–4) and pattern (4 bits; bit=1 dash, bit=0 dot; first symbol in bit 3).
- Timing:
  - dot = 1 unit high, dash = 3 units high.
  - intra-letter space = 1 unit low.
  - inter-letter gap = 3 units low, appended after every letter.
- Handshake: transfer occurs on an edge with in_valid && in_ready. in_ready = (state==IDLE) || (state==GAP && last cycle of gap). Accepting in the last gap cycle gives back-to-back letters with exactly 3 low units between them.
- FSM states:
  - IDLE: out=0, busy=0. On accept of a valid code → MARK, with symbol count loaded and counter = (1 or 3)*UNIT_CYCLES.
  - MARK: out=1. When the counter expires: if symbols remain → SPACE (1 unit); else → GAP (3 units).
  - SPACE: out=0. When the counter expires → MARK for the next symbol.
  - GAP: out=0, busy=1. Final cycle asserts done. Then → IDLE, or → MARK if a new letter is accepted on that edge.
- Latency: out rises on the first clock edge after the accepting edge, i.e. the cycle following the handshake.
- Invalid codes (26–31):
  - The handshake completes and err pulses in the following cycle.
  - State stays IDLE and out stays 0; done does not pulse.
  - Invalid code accepted in the last GAP cycle: the encoder → IDLE and err pulses.
- Total cycles per letter = UNIT_CYCLES × (Σ marks + (len−1) + 3). Examples: 'e'=4, 'a'=8, 'o'=14 units.
- in_valid deasserted while busy has no effect. letter is sampled only on the accepting edge.

Optional Feature:
- MORSE_WORD_GAP_EN defined:
  - Code 26 is a valid word-space token.
  - On accept → GAP loaded with 7 units low; busy=1; done pulses on the final cycle; no err.
  - Back-to-back rules apply as for any GAP.
- MORSE_WORD_GAP_EN undefined: code 26 is invalid (err pulse, no output).

Decomposition:
- Shared package `morse_pkg`:
  - letter-code width (5), MORSE_MAX_SYMS=4
  - unit multipliers DOT=1, DASH=3, SYM_GAP=1, LETTER_GAP=3, WORD_GAP=7
  - state enum {IDLE, MARK, SPACE, GAP}
  - code constants LETTER_MAX=25, WORD_SPACE=26
- One sub-module, `morse_rom`: combinational letter → {length[2:0], pattern[3:0]}, mirroring `display_rom`.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 → out=0, in_ready=1, busy=0, no accept. Assert rst_n mid-'o' → out=0 in the same cycle (async).
- UNIT_CYCLES=1, send 'a' (0) → out from next cycle = 1,0,1,1,1,0,0,0; done high on the 8th cycle; busy high for all 8 cycles.
- Back-to-back: in_valid held, 'e'(4) then 't'(19) → 1,0,0,0,1,1,1,0,0,0. Exactly 3 zeros between letters; 2 done pulses.
- UNIT_CYCLES=4, send 'o'(14) → three 12-cycle highs separated by 4-cycle lows, then 12 low; total 56 cycles.
- Send 27 → err pulses once, out stays 0, in_ready stays 1. Send 26 without MORSE_WORD_GAP_EN → err; with it defined → 7 units low, done pulse, no err.
- Loopback: morse_encoder.out → decoder.in for each letter 0..25 → decoder letter equals the sent code.

Source files
------------

// File: rtl/morse_pkg.sv
// morse_pkg: shared constants, unit multipliers and FSM state type for the Morse encoder.
//   LETTER_W        letter code width
//   MORSE_MAX_SYMS  longest letter in symbols
//   DOT/DASH/SYM_GAP/LETTER_GAP/WORD_GAP  durations in Morse units
//   LETTER_MAX/WORD_SPACE                 code space boundaries
package morse_pkg;
   localparam int LETTER_W       = 5;
   localparam int MORSE_MAX_SYMS = 4;
   localparam int DOT            = 1;
   localparam int DASH           = 3;
   localparam int SYM_GAP        = 1;
   localparam int LETTER_GAP     = 3;
   localparam int WORD_GAP       = 7;
   localparam int LETTER_MAX     = 25;
   localparam int WORD_SPACE     = 26;
   typedef enum logic [1:0] {IDLE, MARK, SPACE, GAP} state_t;
endpackage

// File: rtl/morse_rom.sv
// morse_rom: combinational letter -> Morse length and symbol pattern.
//   letter_i  letter code (0..25 valid, others give length 0)
//   len_o     number of symbols (1..4)
//   pat_o     symbols, first in bit 3, 1 = dash, 0 = dot
module morse_rom
   import morse_pkg::*;
(
   input  logic [LETTER_W-1:0] letter_i,
   output logic [2:0]          len_o,
   output logic [3:0]          pat_o
);
   logic [6:0] rom;
   always_comb begin
      case (letter_i)
         5'd0:    rom = {3'd2, 4'b0100};
         5'd1:    rom = {3'd4, 4'b1000};
         5'd2:    rom = {3'd4, 4'b1010};
         5'd3:    rom = {3'd3, 4'b1000};
         5'd4:    rom = {3'd1, 4'b0000};
         5'd5:    rom = {3'd4, 4'b0010};
         5'd6:    rom = {3'd3, 4'b1100};
         5'd7:    rom = {3'd4, 4'b0000};
         5'd8:    rom = {3'd2, 4'b0000};
         5'd9:    rom = {3'd4, 4'b0111};
         5'd10:   rom = {3'd3, 4'b1010};
         5'd11:   rom = {3'd4, 4'b0100};
         5'd12:   rom = {3'd2, 4'b1100};
         5'd13:   rom = {3'd2, 4'b1000};
         5'd14:   rom = {3'd3, 4'b1110};
         5'd15:   rom = {3'd4, 4'b0110};
         5'd16:   rom = {3'd4, 4'b1101};
         5'd17:   rom = {3'd3, 4'b0100};
         5'd18:   rom = {3'd3, 4'b0000};
         5'd19:   rom = {3'd1, 4'b1000};
         5'd20:   rom = {3'd3, 4'b0010};
         5'd21:   rom = {3'd4, 4'b0001};
         5'd22:   rom = {3'd3, 4'b0110};
         5'd23:   rom = {3'd4, 4'b1001};
         5'd24:   rom = {3'd4, 4'b1011};
         5'd25:   rom = {3'd4, 4'b1100};
         default: rom = 7'd0;
      endcase
   end
   assign len_o = rom[6:4];
   assign pat_o = rom[3:0];
endmodule

// File: rtl/morse_encoder.sv
// morse_encoder: serialises a letter code into a unit-timed Morse key stream.
//   clk, rst_n        clock, asynchronous active-low reset
//   letter, in_valid  letter code offered over valid/ready
//   in_ready          letter can be accepted this cycle
//   out               registered key output, 1 = key down
//   busy              letter or gap in progress
//   done              pulse on the final cycle of the trailing gap
//   err               pulse the cycle after an invalid code is accepted
// Build option: MORSE_WORD_GAP_EN makes code 26 a 7-unit word-space token.
module morse_encoder
   import morse_pkg::*;
#(
   parameter int UNIT_CYCLES = 1,
   parameter int CNT_W       = $clog2(7*UNIT_CYCLES+1)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [LETTER_W-1:0] letter,
   input  logic                in_valid,
   output logic                in_ready,
   output logic                out,
   output logic                busy,
   output logic                done,
   output logic                err
);
   localparam logic [CNT_W-1:0] C_DOT  = CNT_W'(DOT*UNIT_CYCLES);
   localparam logic [CNT_W-1:0] C_DASH = CNT_W'(DASH*UNIT_CYCLES);
   localparam logic [CNT_W-1:0] C_SYM  = CNT_W'(SYM_GAP*UNIT_CYCLES);
   localparam logic [CNT_W-1:0] C_LGAP = CNT_W'(LETTER_GAP*UNIT_CYCLES);
   localparam logic [CNT_W-1:0] C_WGAP = CNT_W'(WORD_GAP*UNIT_CYCLES);
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       syms_q, syms_d;
   logic [3:0]       pat_q, pat_d;
   logic             out_q, busy_q, done_q, err_q, err_d;
   logic [2:0]       len;
   logic [3:0]       pat;
   logic             last, accept, is_letter, is_word;
   morse_rom u_rom (.letter_i(letter), .len_o(len), .pat_o(pat));
   assign last      = cnt_q == CNT_W'(1);
   assign in_ready  = (state_q == IDLE) || (state_q == GAP && last);
   assign accept    = in_valid && in_ready;
   assign is_letter = letter <= LETTER_W'(LETTER_MAX);
`ifdef MORSE_WORD_GAP_EN
   assign is_word   = letter == LETTER_W'(WORD_SPACE);
`else
   assign is_word   = 1'b0;
`endif
   // cnt_q holds cycles left in the current phase; a phase ends when it reads 1
   always_comb begin
      state_d = state_q;
      cnt_d   = state_q == IDLE ? cnt_q : cnt_q - CNT_W'(1);
      syms_d  = syms_q;
      pat_d   = pat_q;
      err_d   = 1'b0;
      if (accept) begin
         err_d   = !is_letter && !is_word;
         state_d = is_letter ? MARK : is_word ? GAP : IDLE;
         cnt_d   = is_letter ? (pat[3] ? C_DASH : C_DOT) : is_word ? C_WGAP : '0;
         syms_d  = 2'(len - 3'd1);
         pat_d   = {pat[2:0], 1'b0};
      end else if (last) begin
         case (state_q)
            MARK: begin
               state_d = syms_q != 2'd0 ? SPACE : GAP;
               cnt_d   = syms_q != 2'd0 ? C_SYM : C_LGAP;
            end
            SPACE: begin
               state_d = MARK;
               cnt_d   = pat_q[3] ? C_DASH : C_DOT;
               pat_d   = {pat_q[2:0], 1'b0};
               syms_d  = syms_q - 2'd1;
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         syms_q  <= '0;
         pat_q   <= '0;
         out_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         syms_q  <= syms_d;
         pat_q   <= pat_d;
         out_q   <= state_d == MARK;
         busy_q  <= state_d != IDLE;
         done_q  <= state_d == GAP && cnt_d == CNT_W'(1);
         err_q   <= err_d;
      end
   end
   assign out  = out_q;
   assign busy = busy_q;
   assign done = done_q;
   assign err  = err_q;
endmodule

// File: tb/tb_morse_encoder.sv
// tb_morse_encoder: scoreboard bench for morse_encoder at 1 and 4 cycles per unit.
module tb_morse_encoder;
   typedef struct {
      bit           err;
      logic [127:0] bits;
      int           len;
      int           gb;
   } exp_t;
   logic clk = 1'b0, rst_n = 1'b0;
   logic [4:0] lt1 = '0, lt4 = '0;
   logic v1 = 1'b1, v4 = 1'b1;
   logic rdy1, o1, b1, dn1, er1, rdy4, o4, b4, dn4, er4;
   int vectors = 0, miscompares = 0;
   exp_t q0[$], q1[$];
   logic [127:0] acc[2];
   int n[2], idle[2], st_gb[2];
   string mt[26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
                     "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
                     "..-", "...-", ".--", "-..-", "-.--", "--.."};
   always #5 clk = ~clk;
   morse_encoder #(.UNIT_CYCLES(1)) u1 (.clk(clk), .rst_n(rst_n), .letter(lt1), .in_valid(v1),
      .in_ready(rdy1), .out(o1), .busy(b1), .done(dn1), .err(er1));
   morse_encoder #(.UNIT_CYCLES(4)) u4 (.clk(clk), .rst_n(rst_n), .letter(lt4), .in_valid(v4),
      .in_ready(rdy4), .out(o4), .busy(b4), .done(dn4), .err(er4));
   function automatic exp_t mk(input string m, input int u, input int gap, input int gb);
      exp_t e;
      e.err = 1'b0; e.bits = '0; e.len = 0; e.gb = gb;
      for (int i = 0; i < m.len(); i++) begin
         for (int j = 0; j < ((m[i] == 8'h2D) ? 3 : 1) * u; j++) begin
            e.bits = {e.bits[126:0], 1'b1}; e.len++;
         end
         if (i < m.len() - 1)
            for (int j = 0; j < u; j++) begin e.bits = {e.bits[126:0], 1'b0}; e.len++; end
      end
      for (int j = 0; j < gap * u; j++) begin e.bits = {e.bits[126:0], 1'b0}; e.len++; end
      return e;
   endfunction
   task automatic mon(input int k, input logic o, input logic b, input logic dn, input logic er,
                      input logic rdy);
      exp_t e;
      if (!rst_n) begin
         acc[k] = '0; n[k] = 0; idle[k] = 0;
         return;
      end
      if (!b && o) begin
         miscompares++;
         $display("FAIL idle_out dut%0d: out=%b while busy=0", k, o);
      end
      if (b) begin
         if (n[k] == 0) st_gb[k] = idle[k];
         acc[k] = {acc[k][126:0], o};
         n[k]++;
      end else idle[k]++;
      if (dn) begin
         vectors++;
         if ((k == 0 ? q0.size() : q1.size()) == 0) begin
            miscompares++;
            $display("FAIL spurious_done dut%0d: got done, want none", k);
         end else begin
            e = k == 0 ? q0.pop_front() : q1.pop_front();
            if (e.err || e.len != n[k] || e.bits != acc[k]) begin
               miscompares++;
               $display("FAIL stream dut%0d: got len=%0d bits=%h, want err=%0b len=%0d bits=%h",
                        k, n[k], acc[k], e.err, e.len, e.bits);
            end
            if (e.gb >= 0) begin
               vectors++;
               if (st_gb[k] != e.gb) begin
                  miscompares++;
                  $display("FAIL b2b_gap dut%0d: got %0d idle cycles, want %0d", k, st_gb[k], e.gb);
               end
            end
         end
         acc[k] = '0; n[k] = 0; idle[k] = 0;
      end
      if (er) begin
         vectors++;
         if ((k == 0 ? q0.size() : q1.size()) == 0) begin
            miscompares++;
            $display("FAIL spurious_err dut%0d: got err, want none", k);
         end else begin
            e = k == 0 ? q0.pop_front() : q1.pop_front();
            if (!e.err || o || b || !rdy) begin
               miscompares++;
               $display("FAIL err_pulse dut%0d: got out=%b busy=%b ready=%b expect_err=%0b, want 0 0 1 1",
                        k, o, b, rdy, e.err);
            end
         end
      end
   endtask
   always @(negedge clk) begin
      mon(0, o1, b1, dn1, er1, rdy1);
      mon(1, o4, b4, dn4, er4, rdy4);
   end
   task automatic send(input int d, input int l, input bit b2b, input int gb);
      exp_t e;
      int t = 0;
      logic want;
      e.err = 1'b1; e.bits = '0; e.len = 0; e.gb = -1;
      if (l <= 25) e = mk(mt[l], d ? 4 : 1, 3, gb);
`ifdef MORSE_WORD_GAP_EN
      if (l == 26) e = mk("", d ? 4 : 1, 7, gb);
`endif
      if (d == 0) begin q0.push_back(e); lt1 = 5'(l); v1 = 1'b1; end
      else begin q1.push_back(e); lt4 = 5'(l); v4 = 1'b1; end
      while (!(d ? rdy4 : rdy1) && t < 400) begin @(negedge clk); t++; end
      if (t >= 400) begin
         $display("FAIL ready_timeout dut%0d: in_ready stayed 0, want 1", d);
         $fatal(1, "ready timeout");
      end
      @(posedge clk);
      @(negedge clk);
      want = e.err ? 1'b0 : e.bits[e.len-1];
      vectors++;
      if ((d ? o4 : o1) != want) begin
         miscompares++;
         $display("FAIL latency dut%0d code %0d: got out=%b, want %b", d, l, d ? o4 : o1, want);
      end
      if (!b2b) begin if (d == 0) v1 = 1'b0; else v4 = 1'b0; end
   endtask
   initial begin
      int t = 0;
      repeat (3) @(negedge clk);
      vectors++;
      if (o1 || !rdy1 || b1 || o4 || !rdy4 || b4) begin
         miscompares++;
         $display("FAIL reset_state: got out=%b%b ready=%b%b busy=%b%b, want 00 11 00",
                  o1, o4, rdy1, rdy4, b1, b4);
      end
      v1 = 1'b0; v4 = 1'b0;
      #1 rst_n = 1'b1;
      @(negedge clk);
      vectors++;
      if (b1 || b4) begin
         miscompares++;
         $display("FAIL no_accept_in_reset: got busy=%b%b, want 00", b1, b4);
      end
      lt1 = 5'd14; v1 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      v1 = 1'b0;
      vectors++;
      if (!o1) begin
         miscompares++;
         $display("FAIL mid_o_start: got out=%b, want 1", o1);
      end
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if (o1 || b1 || !rdy1) begin
         miscompares++;
         $display("FAIL async_abort: got out=%b busy=%b ready=%b, want 0 0 1", o1, b1, rdy1);
      end
      @(negedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      vectors++;
      if (b1 || o1) begin
         miscompares++;
         $display("FAIL no_resume: got busy=%b out=%b, want 0 0", b1, o1);
      end
      send(0, 0, 0, -1);
      send(0, 4, 1, -1);
      send(0, 19, 0, 0);
      send(1, 14, 0, -1);
      send(0, 27, 0, -1);
      send(0, 26, 0, -1);
      send(0, 4, 1, -1);
      send(0, 28, 0, -1);
      send(1, 9, 0, -1);
      send(1, 26, 0, -1);
      for (int l = 0; l < 26; l++) send(0, l, 1, l == 0 ? -1 : 0);
      v1 = 1'b0;
      while ((q0.size() != 0 || q1.size() != 0 || b1 || b4) && t < 3000) begin
         @(negedge clk); t++;
      end
      repeat (3) @(negedge clk);
      vectors++;
      if (q0.size() != 0) begin
         miscompares++;
         $display("FAIL drain_dut0: got %0d pending, want 0", q0.size());
      end
      vectors++;
      if (q1.size() != 0) begin
         miscompares++;
         $display("FAIL drain_dut1: got %0d pending, want 0", q1.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
